musicbox_sdram_arbiter: RTL



---
 rtl/musicbox_sdram_pkg.sv | 14 +
 rtl/musicbox_rr_picker.sv | 29 ++
 rtl/musicbox_sdram_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/musicbox_sdram_pkg.sv
// Shared types and constants for the music box SDRAM arbiter.
package musicbox_sdram_pkg;
   localparam int SDRAM_ADDR_W       = 25;
   localparam int SDRAM_DATA_W       = 16;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int CNT_W              = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_READ,
      RECOVER
   } arb_state_t;
endpackage

// File: rtl/musicbox_rr_picker.sv
// Combinational round-robin picker: first set request above last_i.
module musicbox_rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o
);

   always_comb begin
      logic found;
      int   pos;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = (int'(last_i) + k) % NUM_REQ;
         if (!found && req_i[pos]) begin
            found        = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/musicbox_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between
// the record, playback and tone requesters; one command in flight.
module musicbox_sdram_arbiter
   import musicbox_sdram_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                         clock_50Mhz,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_isWriting,
   input  logic [NUM_REQ*SDRAM_ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*SDRAM_DATA_W-1:0] req_writeData,
   output logic [NUM_REQ-1:0]           req_accept,
   output logic [NUM_REQ-1:0]           req_readValid,
   output logic [NUM_REQ-1:0]           req_error,
   output logic [SDRAM_DATA_W-1:0]      req_readData,
   output logic [SDRAM_ADDR_W-1:0]      sdram_inputAddress,
   output logic [SDRAM_DATA_W-1:0]      sdram_writeData,
   output logic                         sdram_isWriting,
   output logic                         sdram_inputValid,
   input  logic [SDRAM_DATA_W-1:0]      sdram_readData,
   input  logic                         sdram_outputValid,
   input  logic                         sdram_recievedCommand,
   input  logic                         sdram_isBusy,
   output logic [31:0]                  debugString
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t              state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SDRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic                    wr_q, wr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    seen_q, seen_d;
   logic [SDRAM_DATA_W-1:0] cap_q, cap_d;
   logic [SDRAM_DATA_W-1:0] rdata_q, rdata_d;
   logic [NUM_REQ-1:0]      acc_q, acc_d;
   logic [NUM_REQ-1:0]      rv_q, rv_d;
   logic [NUM_REQ-1:0]      err_q, err_d;
   logic [NUM_REQ-1:0]      pick_oh;
   logic [IDX_W-1:0]        pick_idx;
   logic                    timeout;

   musicbox_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (req_valid),
      .last_i  (last_q),
      .grant_o (pick_oh),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      acc_d   = '0;
      rv_d    = '0;
      err_d   = '0;
      timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      if ((state_q == ISSUE || state_q == WAIT_READ) && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (|req_valid && !sdram_isBusy) begin
               owner_d = pick_idx;
               last_d  = pick_idx;
               wr_d    = req_isWriting[pick_idx];
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (pick_oh[i]) begin
                     addr_d  = req_address[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                     wdata_d = req_writeData[i*SDRAM_DATA_W +: SDRAM_DATA_W];
                  end
               end
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (sdram_recievedCommand) begin
               acc_d[owner_q] = 1'b1;
               if (wr_q) begin
                  state_d = RECOVER;
               end else begin
                  cnt_d   = '0;
                  seen_d  = 1'b0;
                  state_d = WAIT_READ;
               end
            end else if (timeout) begin
               err_d[owner_q] = 1'b1;
               state_d        = RECOVER;
            end
         end
         WAIT_READ: begin
            // Data is delivered on the strobe's falling edge: last beat wins.
            if (sdram_outputValid) begin
               cap_d  = sdram_readData;
               seen_d = 1'b1;
            end
            if (!sdram_outputValid && seen_q) begin
               rv_d[owner_q] = 1'b1;
               rdata_d       = cap_q;
               state_d       = RECOVER;
            end else if (timeout) begin
               err_d[owner_q] = 1'b1;
               state_d        = RECOVER;
            end
         end
         RECOVER: begin
            if (!sdram_isBusy)
               state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         cap_q   <= '0;
         rdata_q <= '0;
         acc_q   <= '0;
         rv_q    <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         acc_q   <= acc_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign req_accept         = acc_q;
   assign req_readValid      = rv_q;
   assign req_error          = err_q;
   assign req_readData       = rdata_q;
   assign sdram_inputAddress = addr_q;
   assign sdram_writeData    = wdata_q;
   assign sdram_inputValid   = (state_q == ISSUE);
   assign sdram_isWriting    = (state_q == ISSUE) && wr_q;
   assign debugString        = {8'(state_q), 8'(owner_q), cnt_q};

endmodule
